// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (dmem_arbiter).
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration instead of fixed priority with starvation limit.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the two data-memory requesters.
// Port 1 wins a tie when it is the preferred port (round-robin) or is starving (fixed priority).
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic rr_ptr,
  input  logic starve,
  output logic any_valid,
  output logic winner
);

  // The top ties the input that its arbitration mode does not use to 0,
  // so one tie-break expression serves both modes.
  always_comb begin
    any_valid = valid0 | valid1;
    winner    = PORT_CORE;
    if (valid1 && (!valid0 || (rr_ptr == PORT_DBG) || starve)) begin
      winner = PORT_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: IDLE -> ACCESS -> RESP, one transaction at a time.
// Build option: DMEM_ARB_RR_EN selects round-robin; otherwise fixed priority (port 0) with a port-1 starvation limit.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,

  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,

  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,

  output state_t            dbg_state
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_DEPTH) << 2;

  state_t            state;
  logic              any_valid;
  logic              win;
  logic              grant;
  logic              rr_ptr;
  logic              starve;

  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_err;

  logic              lat_id;
  logic              lat_we;
  logic              lat_err;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic [1:0]        rsp_vld_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              in_access;

  dmem_arb_pick u_pick (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .rr_ptr    (rr_ptr),
    .starve    (starve),
    .any_valid (any_valid),
    .winner    (win)
  );

  // Handshake: a requester raises reqN_valid with a stable payload and holds it
  // until reqN_ready pulses for one IDLE cycle; that pulse is the accept. The
  // matching rspN_valid pulse follows exactly two cycles later.
  assign grant      = (state == IDLE) && any_valid && !rst;
  assign req0_ready = grant && (win == PORT_CORE);
  assign req1_ready = grant && (win == PORT_DBG);

  always_comb begin
    win_we    = req0_we;
    win_addr  = req0_addr;
    win_wdata = req0_wdata;
    if (win == PORT_DBG) begin
      win_we    = req1_we;
      win_addr  = req1_addr;
      win_wdata = req1_wdata;
    end
    win_err = (win_addr[1:0] != 2'b00) || ({1'b0, win_addr} >= ADDR_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_id      <= PORT_CORE;
      lat_we      <= 1'b0;
      lat_err     <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rsp_vld_q   <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            lat_id    <= win;
            lat_we    <= win_we;
            lat_err   <= win_err;
            lat_addr  <= win_addr;
            lat_wdata <= win_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_vld_q   <= (lat_id == PORT_DBG) ? 2'b10 : 2'b01;
          rsp_rdata_q <= (lat_we || lat_err) ? '0 : mem_rd;
          rsp_err_q   <= lat_err;
          state       <= RESP;
        end
        RESP: begin
          rsp_vld_q   <= 2'b00;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_RR_EN
  // rr_ptr names the port that wins the next tie.
  assign starve = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= PORT_CORE;
    end else if (grant) begin
      rr_ptr <= ~win;
    end
  end
`else
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [SW-1:0] starve_cnt;

  assign rr_ptr = PORT_CORE;
  assign starve = (starve_cnt == SW'(STARVE_LIM));

  // Counts IDLE cycles in which port 1 asked and lost; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant && (win == PORT_DBG)) begin
      starve_cnt <= '0;
    end else if (grant && req1_valid && !starve) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  // Reset in the ACCESS cycle must suppress the memory write, so gate with rst.
  assign in_access = (state == ACCESS) && !rst;
  assign mem_a     = in_access ? {2'b00, lat_addr[ADDR_W-1:2]} : '0;
  assign mem_wd    = in_access ? lat_wdata : '0;
  assign mem_we    = in_access && lat_we && !lat_err;

  assign rsp0_valid = rsp_vld_q[0] && !rst;
  assign rsp1_valid = rsp_vld_q[1] && !rst;
  assign rsp0_rdata = rsp0_valid ? rsp_rdata_q : '0;
  assign rsp1_rdata = rsp1_valid ? rsp_rdata_q : '0;
  assign rsp0_err   = rsp0_valid && rsp_err_q;
  assign rsp1_err   = rsp1_valid && rsp_err_q;

  assign dbg_state  = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024-word memory attached.
// Honours DMEM_ARB_RR_EN for the arbitration-order expectations.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req0_ready, rsp0_valid, rsp0_err;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req1_ready, rsp1_valid, rsp1_err;
  logic [DW-1:0] rsp1_rdata;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd, mem_rd;
  logic          mem_we;
  state_t        dbg_state;

  logic [DW-1:0] mem [0:1023];
  logic [0:0]    exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(1024), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .dbg_state(dbg_state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  assign mem_rd = (mem_a < 32'd1024) ? mem[mem_a[9:0]] : '0;

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[9:0]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after posedge; outputs are sampled at negedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    step();
    rst = 1'b0;
  endtask

  task automatic drive(input logic port, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    if (port == PORT_CORE) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end
  endtask

  // Full single-port transaction from IDLE, checking every cycle of the 3-cycle sequence.
  task automatic do_txn(input string tag, input logic port, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic exp_err, input logic [DW-1:0] exp_rdata);
    drive(port, we, addr, wdata);
    @(negedge clk);
    check({tag, "_ready"}, (port == PORT_CORE) ? req0_ready : req1_ready, 1'b1);
    check({tag, "_idle_we"}, mem_we, 1'b0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check({tag, "_acc_ready"}, req0_ready | req1_ready, 1'b0);
    check({tag, "_mem_a"}, mem_a, addr >> 2);
    check({tag, "_mem_we"}, mem_we, we & ~exp_err);
    if (we && !exp_err) check({tag, "_mem_wd"}, mem_wd, wdata);
    step();
    @(negedge clk);
    check({tag, "_rsp_valid"}, {rsp1_valid, rsp0_valid}, (port == PORT_CORE) ? 2'b01 : 2'b10);
    check({tag, "_rsp_err"}, (port == PORT_CORE) ? rsp0_err : rsp1_err, exp_err);
    check({tag, "_rsp_rdata"}, (port == PORT_CORE) ? rsp0_rdata : rsp1_rdata, exp_rdata);
    check({tag, "_resp_mem_we"}, mem_we, 1'b0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // reset state
    do_reset();
    @(negedge clk);
    check("rst_outs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, mem_we},
          7'b0);
    check("rst_mem_a", mem_a, 32'h0);
    step();

    // write then read back
    do_txn("wr10", PORT_CORE, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    check("wr10_mem", mem[4], 32'hDEADBEEF);
    do_txn("rd10", PORT_CORE, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    do_txn("rd10_p1", PORT_DBG, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    // misaligned and out-of-range
    do_txn("mis3", PORT_DBG, 1'b0, 32'h3, 32'h0, 1'b1, 32'h0);
    do_txn("wr0", PORT_CORE, 1'b1, 32'h0, 32'hA5A5_0001, 1'b0, 32'h0);
    do_txn("oor", PORT_CORE, 1'b1, 32'h1000, 32'h1234_5678, 1'b1, 32'h0);
    do_txn("rd0", PORT_CORE, 1'b0, 32'h0, 32'h0, 1'b0, 32'hA5A5_0001);
    do_txn("oor_last", PORT_DBG, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'h0);

    // reset during ACCESS of a write
    drive(PORT_CORE, 1'b1, 32'h20, 32'h0000_0055);
    @(negedge clk);
    check("rsta_ready", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rsta_mem_we", mem_we, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rsta_state", 64'(dbg_state), 64'(IDLE));
    check("rsta_outs", {rsp0_valid, rsp1_valid, mem_we, req0_ready}, 4'b0);
    check("rsta_mem", mem[8], 32'h0);
    step();
    do_txn("rsta_new", PORT_CORE, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);

    // request presented during RESP waits for IDLE
    drive(PORT_CORE, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("dr_ready0", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    step();
    drive(PORT_DBG, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("dr_resp_ready1", req1_ready, 1'b0);
    check("dr_rsp0", rsp0_rdata, 32'hDEADBEEF);
    step();
    @(negedge clk);
    check("dr_idle_ready1", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    step();
    @(negedge clk);
    check("dr_rsp1_valid", rsp1_valid, 1'b1);
    check("dr_rsp1_rdata", rsp1_rdata, 32'hDEADBEEF);
    step();

    // both ports valid every cycle: grant order
    do_reset();
`ifdef DMEM_ARB_RR_EN
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
    drive(PORT_CORE, 1'b0, 32'h0, 32'h0);
    drive(PORT_DBG, 1'b0, 32'h4, 32'h0);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      check("arb_onehot", req0_ready & req1_ready, 1'b0);
      if (req0_ready || req1_ready) begin
        if (exp_q.size() == 0) begin
          check("arb_extra_grant", 1'b1, 1'b0);
        end else begin
          check($sformatf("arb_grant%0d", c / 3), req1_ready, exp_q.pop_front());
        end
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("arb_left", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
